// File: rtl/riscv_mem_pkg.sv
// Shared types and defaults for the unified memory arbiter.
// Holds the arbiter state and owner encodings, the default memory depth,
// and the largest supported memory read latency.
package riscv_mem_pkg;

  typedef enum logic {IDLE, WAIT_RD} arb_state_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

  localparam int MEM_WORDS_DEF = 1024;
  localparam int MEM_LAT_MAX   = 4;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the core (fetch and load/store ports), the arbiter and
// the unified memory array.
//   slave  : arbiter view. Requests and mem_rdata come in. Grants, rvalid/rdata
//            and the memory strobe/address/data go out.
//   master : core + memory view, the mirror image of slave.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 10
);
  // fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  // load/store port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  // memory side
  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one unified instruction/data memory between the fetch port
// and the load/store port. Only one transaction is in flight at a time.
//   clock, reset_n : rising-edge clock, async active-low reset
//   bus (slave)    : if_* fetch port, d_* load/store port, mem_* memory port
// Data requests have priority. A fetch that has lost STARVE_LIMIT arbitration
// cycles in a row wins the next one. Stores finish in the grant cycle. Loads
// and fetches hold the memory for MEM_LAT further cycles, and the owner's
// rvalid pulses in the last of those cycles. MEM_LAT must be in 1..MEM_LAT_MAX.
module unified_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_WORDS    = MEM_WORDS_DEF,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  unified_mem_arbiter_if.slave  bus
);

  localparam int MEM_AW = $clog2(MEM_WORDS);
  localparam int LAT_W  = $clog2(MEM_LAT_MAX + 1);
  localparam int SC_W   = $clog2(STARVE_LIMIT + 1);

  arb_state_t        state;
  owner_t            owner;
  logic [LAT_W-1:0]  lat_cnt;
  logic [SC_W-1:0]   starve_cnt;

  logic              starved;
  logic              if_win;
  logic              d_win;
  logic              rd_done;
  logic [MEM_AW-1:0] if_idx;
  logic [MEM_AW-1:0] d_idx;

  // Word index: the byte offset is dropped and the high bits are truncated,
  // so addresses wrap around the array.
  assign if_idx = bus.if_addr[MEM_AW+1:2];
  assign d_idx  = bus.d_addr[MEM_AW+1:2];

  // The grant is combinational so the winner's address reaches the memory in
  // the same cycle. The reset_n gating keeps every strobe low while reset is held.
  always_comb begin
    starved = (starve_cnt == SC_W'(STARVE_LIMIT));
    if_win  = reset_n && (state == IDLE) && bus.if_req && (!bus.d_req || starved);
    d_win   = reset_n && (state == IDLE) && bus.d_req && !if_win;
    rd_done = reset_n && (state == WAIT_RD) && (lat_cnt == LAT_W'(MEM_LAT));
  end

  assign bus.if_gnt    = if_win;
  assign bus.d_gnt     = d_win;
  assign bus.if_rvalid = rd_done && (owner == OWN_IF);
  assign bus.d_rvalid  = rd_done && (owner == OWN_D);
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

  assign bus.mem_en    = if_win || d_win;
  assign bus.mem_we    = d_win && bus.d_we;
  assign bus.mem_addr  = if_win ? if_idx : d_idx;
  assign bus.mem_wdata = bus.d_wdata;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Count only the cycles in which fetch was waiting and data took the memory.
          if (if_win)
            starve_cnt <= '0;
          else if (d_win && bus.if_req && !starved)
            starve_cnt <= starve_cnt + 1'b1;
          // A store completes in its grant cycle, so only reads leave IDLE.
          if (if_win || (d_win && !bus.d_we)) begin
            state   <= WAIT_RD;
            owner   <= if_win ? OWN_IF : OWN_D;
            lat_cnt <= LAT_W'(1);
          end
        end
        WAIT_RD: begin
          if (rd_done) begin
            state   <= IDLE;
            owner   <= OWN_NONE;
            lat_cnt <= '0;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          owner <= OWN_NONE;
        end
      endcase
    end
  end

endmodule
